vga_timing_gen: RTL and testbench

//  VGA raster timing generator; sits directly downstream of the pixel-clock strobe divider.

---
 rtl/vga_timing_pkg.sv | 63 ++++++
 rtl/vga_axis_counter.sv | 84 ++++++++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared types and default timing for the VGA raster generator.
//   - phase_e        : raster phase of one axis (active, front porch, sync,
//                      back porch), in the order the raster visits them.
//   - VGA_*          : 640x480@60 default phase lengths (pixels / lines).
//   - phase_len()    : length of a given phase, from the four axis lengths.
//   - next_phase()   : successor phase in raster order.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    // 640x480@60 horizontal timing, in pixels
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // 640x480@60 vertical timing, in lines
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    function automatic int unsigned phase_len(
        input phase_e      ph,
        input int unsigned len_active,
        input int unsigned len_fp,
        input int unsigned len_sync,
        input int unsigned len_bp
    );
        int unsigned len;
        len = len_active;
        case (ph)
            PH_ACTIVE: len = len_active;
            PH_FP:     len = len_fp;
            PH_SYNC:   len = len_sync;
            PH_BP:     len = len_bp;
            default:   len = len_active;
        endcase
        return len;
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        nxt = PH_ACTIVE;
        case (ph)
            PH_ACTIVE: nxt = PH_FP;
            PH_FP:     nxt = PH_SYNC;
            PH_SYNC:   nxt = PH_BP;
            PH_BP:     nxt = PH_ACTIVE;
            default:   nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis: a position counter 0..TOTAL-1 plus a phase FSM that walks
//   ACTIVE -> FP -> SYNC -> BP -> ACTIVE, spending exactly its parameterised
//   number of enables in each phase. Used once for H (enabled by the pixel
//   strobe) and once for V (enabled by the H wrap).
// Ports
//   clk_i    in   1      clock
//   rst_i    in   1      synchronous reset, active-high
//   en_i     in   1      advance one step on this clock edge
//   pos_o    out  POS_W  current position within the axis
//   phase_o  out  2      current phase (phase_e)
//   wrap_o   out  1      en_i while at TOTAL-1: this edge returns pos_o to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter  int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter  int unsigned FP     = VGA_H_FP,
    parameter  int unsigned SYNC   = VGA_H_SYNC,
    parameter  int unsigned BP     = VGA_H_BP,
    localparam int unsigned TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int unsigned POS_W  = $clog2(TOTAL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [POS_W-1:0] pos_o,
    output phase_e           phase_o,
    output logic             wrap_o
);

    // A zero-length phase would make the FSM skip a state and desynchronise
    // the phase from the position, so refuse to elaborate.
    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_param
        $error("vga_axis_counter: every phase length must be >= 1");
    end

    phase_e           phase_q,  phase_d;
    logic [POS_W-1:0] pos_q,    pos_d;
    logic [POS_W-1:0] ph_cnt_q, ph_cnt_d;   // enables spent in current phase
    logic             last_pos;
    logic             last_in_phase;

    assign last_pos      = (pos_q == POS_W'(TOTAL - 1));
    assign last_in_phase = (ph_cnt_q ==
                            POS_W'(phase_len(phase_q, ACTIVE, FP, SYNC, BP) - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of all others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= PH_ACTIVE;
            pos_q    <= '0;
            ph_cnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            pos_q    <= pos_d;
            ph_cnt_q <= ph_cnt_d;
        end
    end

    // NOTE: every next-state signal is given a hold default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_d  = phase_q;
        pos_d    = pos_q;
        ph_cnt_d = ph_cnt_q;
        if (en_i) begin
            pos_d = last_pos ? '0 : pos_q + POS_W'(1);
            if (last_in_phase) begin
                phase_d  = next_phase(phase_q);
                ph_cnt_d = '0;
            end else begin
                ph_cnt_d = ph_cnt_q + POS_W'(1);
            end
        end
    end

    assign pos_o   = pos_q;
    assign phase_o = phase_q;
    assign wrap_o  = en_i & last_pos;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator. The pixel strobe is a clock enable; there is
//   a single clock. Two axis counters track (hpos, vpos); on each strobe the
//   output register stage loads the decode of the pre-increment position, so
//   outputs follow the strobe by one clk and hold between strobes.
// Ports
//   clk_i          in   1       system clock
//   rst_i          in   1       synchronous reset, active-high, wins over strobe
//   pix_strb_i     in   1       pixel enable, one clk wide, any spacing
//   hsync_o        out  1       horizontal sync, active level HSYNC_POL
//   vsync_o        out  1       vertical sync, active level VSYNC_POL
//   de_o           out  1       pixel lies in active H and active V
//   hcount_o       out  HCNT_W  pixel column of the emitted pixel
//   vcount_o       out  VCNT_W  line of the emitted pixel
//   line_start_o   out  1       one-clk pulse: pixel at hcount 0 emitted
//   frame_start_o  out  1       one-clk pulse: pixel at (0,0) emitted
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter  int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter  int unsigned H_FP      = VGA_H_FP,
    parameter  int unsigned H_SYNC    = VGA_H_SYNC,
    parameter  int unsigned H_BP      = VGA_H_BP,
    parameter  int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter  int unsigned V_FP      = VGA_V_FP,
    parameter  int unsigned V_SYNC    = VGA_V_SYNC,
    parameter  int unsigned V_BP      = VGA_V_BP,
    parameter  logic        HSYNC_POL = 1'b0,
    parameter  logic        VSYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HCNT_W    = $clog2(H_TOTAL),
    localparam int unsigned VCNT_W    = $clog2(V_TOTAL)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pix_strb_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic [HCNT_W-1:0] hcount_o,
    output logic [VCNT_W-1:0] vcount_o,
    output logic              line_start_o,
    output logic              frame_start_o
);

    localparam int unsigned H_SYNC_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
    localparam int unsigned V_SYNC_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;

    // ---------------------------------------------------------------- axes
    logic [HCNT_W-1:0] h_pos;
    logic [VCNT_W-1:0] v_pos;
    phase_e            h_phase;
    phase_e            v_phase;
    logic              h_wrap;
    logic              v_wrap;
    logic              v_en;

    assign v_en = pix_strb_i & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (pix_strb_i),
        .pos_o   (h_pos),
        .phase_o (h_phase),
        .wrap_o  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (v_en),
        .pos_o   (v_pos),
        .phase_o (v_phase),
        .wrap_o  (v_wrap)
    );

    // ------------------------------------------------------------- decode
    logic h_in_sync;
    logic v_in_sync;

    assign h_in_sync = (h_pos >= HCNT_W'(H_SYNC_FIRST)) &&
                       (h_pos <= HCNT_W'(H_SYNC_LAST));
    assign v_in_sync = (v_pos >= VCNT_W'(V_SYNC_FIRST)) &&
                       (v_pos <= VCNT_W'(V_SYNC_LAST));

    // first_px_q: the next strobe emits pixel (0,0). Set by reset and by the
    // frame wrap, cleared by any other strobe; avoids a full-width compare.
    logic first_px_q, first_px_d;

    // ------------------------------------------------------ output stage
    logic              hsync_q,       hsync_d;
    logic              vsync_q,       vsync_d;
    logic              de_q,          de_d;
    logic [HCNT_W-1:0] hcount_q,      hcount_d;
    logic [VCNT_W-1:0] vcount_q,      vcount_d;
    logic              line_start_q,  line_start_d;
    logic              frame_start_q, frame_start_d;

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        first_px_d    = first_px_q;
        // Pulses default low so they last one clk whatever the strobe spacing.
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_strb_i) begin
            hsync_d       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
            de_d          = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            hcount_d      = h_pos;
            vcount_d      = v_pos;
            line_start_d  = (h_pos == '0);
            frame_start_d = first_px_q;
            first_px_d    = v_wrap;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            first_px_q    <= 1'b1;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            first_px_q    <= first_px_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench on a small raster: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6).
//   u_dut_lo uses active-low syncs, u_dut_hi active-high; both see the same
//   stimulus. Expected values come from the hand-derived windows:
//   active pixels hpos 0..3, hsync at hpos 5..6, active lines vpos 0..2,
//   vsync at vpos 4.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_strb;

    logic       lo_hs, lo_vs, lo_de, lo_ls, lo_fs;
    logic [2:0] lo_hc, lo_vc;
    logic       hi_hs, hi_vs, hi_de, hi_ls, hi_fs;
    logic [2:0] hi_hc, hi_vc;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_dut_lo (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_strb_i    (pix_strb),
        .hsync_o       (lo_hs),
        .vsync_o       (lo_vs),
        .de_o          (lo_de),
        .hcount_o      (lo_hc),
        .vcount_o      (lo_vc),
        .line_start_o  (lo_ls),
        .frame_start_o (lo_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_dut_hi (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_strb_i    (pix_strb),
        .hsync_o       (hi_hs),
        .vsync_o       (hi_vs),
        .de_o          (hi_de),
        .hcount_o      (hi_hc),
        .vcount_o      (hi_vc),
        .line_start_o  (hi_ls),
        .frame_start_o (hi_fs)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    string test_tag = "init";

    // reference model: raster position and expected output register contents
    int mh = 0, mv = 0;
    bit e_hs, e_vs, e_de, e_ls, e_fs;   // e_hs/e_vs: sync window active
    int e_hc, e_vc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", test_tag, tag, obs, exp);
        end
    endtask

    task automatic verify();
        check("lo.hsync", lo_hs, !e_hs);
        check("lo.vsync", lo_vs, !e_vs);
        check("lo.de",    lo_de, e_de);
        check("lo.hcnt",  lo_hc, e_hc);
        check("lo.vcnt",  lo_vc, e_vc);
        check("lo.lstrt", lo_ls, e_ls);
        check("lo.fstrt", lo_fs, e_fs);
        check("hi.hsync", hi_hs, e_hs);
        check("hi.vsync", hi_vs, e_vs);
        check("hi.de",    hi_de, e_de);
    endtask

    // Drive inputs, take one clock edge, update the model, compare.
    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input bit s, input bit r);
        pix_strb = s;
        rst      = r;
        @(posedge clk);
        #1;
        if (r) begin
            mh = 0; mv = 0;
            e_hs = 0; e_vs = 0; e_de = 0; e_hc = 0; e_vc = 0; e_ls = 0; e_fs = 0;
        end else if (s) begin
            e_hc = mh;
            e_vc = mv;
            e_hs = (mh >= 5 && mh <= 6);
            e_vs = (mv == 4);
            e_de = (mh <= 3 && mv <= 2);
            e_ls = (mh == 0);
            e_fs = (mh == 0 && mv == 0);
            if (mh == 7) begin
                mh = 0;
                mv = (mv == 5) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end else begin
            e_ls = 0;
            e_fs = 0;
        end
        verify();
    endtask

    initial begin
        int fs_cnt, vs_cnt, de_cnt, guard;
        rst      = 1'b1;
        pix_strb = 1'b0;

        // 1. reset, then 20 clks without strobe: reset values hold
        test_tag = "t1_reset";
        step(0, 1);
        step(0, 1);
        for (int i = 0; i < 20; i++) step(0, 0);

        // 2. strobe every clk for one line
        test_tag = "t2_line";
        for (int i = 0; i < 8; i++) step(1, 0);

        // 3. strobe every 4th clk: outputs hold, pulses one clk wide
        test_tag = "t3_sparse";
        for (int i = 0; i < 10; i++) begin
            step(1, 0);
            for (int j = 0; j < 3; j++) step(0, 0);
        end

        // 4. two full frames of back-to-back strobes
        test_tag = "t4_frames";
        fs_cnt = 0; vs_cnt = 0; de_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            step(1, 0);
            if (lo_fs)  fs_cnt++;
            if (!lo_vs) vs_cnt++;
            if (lo_de)  de_cnt++;
        end
        check("fs_per_96", fs_cnt, 2);
        check("vs_low_96", vs_cnt, 16);
        check("de_hi_96",  de_cnt, 24);

        // 5. reset with concurrent strobe at (5,2)
        test_tag = "t5_midrst";
        guard = 0;
        while (!(mh == 5 && mv == 2) && guard < 60) begin
            step(1, 0);
            guard++;
        end
        check("reach_5_2", (mh == 5 && mv == 2), 1);
        step(1, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        check("post_rst_fs", lo_fs, 1);
        check("post_rst_de", lo_de, 1);
        step(1, 0);

        // 6. one more frame to cover both polarities across the sync windows
        test_tag = "t6_pol";
        for (int i = 0; i < 48; i++) step(1, 0);
        step(0, 1);
        check("hi_rst_hs", hi_hs, 0);
        check("hi_rst_vs", hi_vs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
